// File: rtl/mul_rr_sched_pkg.sv
// Shared types and defaults for the round-robin multiplier scheduler.
// Optional build macro MUL_SWAP_EN is consumed by mul_rr_sched.
package mul_sched_pkg;

    localparam int unsigned NumReqDef = 4;
    localparam int unsigned DataWDef  = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StMul,
        StDone
    } state_e;

endpackage

// File: rtl/mul_rr_sched_if.sv
// Requester bus plus datapath control bus of the shared multiplier.
// master = scheduler side, slave = requesters and datapath side.
interface mul_rr_sched_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 16
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]        gnt;
    logic                      busy;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_data;

    logic [DATA_W-1:0]         dp_data;
    logic                      LdA;
    logic                      LdB;
    logic                      LdP;
    logic                      clrP;
    logic                      decB;
    logic                      eqz;
    logic [DATA_W-1:0]         dp_y;

    modport master (
        input  req, req_a, req_b, eqz, dp_y,
        output gnt, busy, rsp_valid, rsp_id, rsp_data,
        output dp_data, LdA, LdB, LdP, clrP, decB
    );

    modport slave (
        output req, req_a, req_b, eqz, dp_y,
        input  gnt, busy, rsp_valid, rsp_id, rsp_data,
        input  dp_data, LdA, LdB, LdP, clrP, decB
    );

endinterface

// File: rtl/mul_rr_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request after ptr_i, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               valid_o
);

    int unsigned     cand;
    logic [ID_W-1:0] cand_idx;

    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand     = (32'(ptr_i) + 32'd1 + i) % NUM_REQ;
            cand_idx = ID_W'(cand);
            if (!valid_o && req_i[cand_idx]) begin
                valid_o         = 1'b1;
                idx_o           = cand_idx;
                gnt_o[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_rr_sched.sv
// Round-robin scheduler sharing one repeated-addition multiplier datapath.
// Define MUL_SWAP_EN to load the smaller operand into B (fewer iterations).
module mul_rr_sched
    import mul_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = NumReqDef,
    parameter int unsigned DATA_W  = DataWDef
) (
    input  logic           clk,
    input  logic           reset_n,
    mul_rr_sched_if.master bus
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     ptr_q;
    logic [ID_W-1:0]     id_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic [DATA_W-1:0]   rsp_data_q;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [ID_W-1:0]     arb_idx;
    logic                arb_valid;
    logic                accept;
    logic [DATA_W-1:0]   sel_a, sel_b;
    logic [DATA_W-1:0]   lat_a, lat_b;

    logic [NUM_REQ-1:0]  gnt;
    logic [DATA_W-1:0]   dp_data;
    logic                ld_a, ld_b, ld_p, clr_p, dec_b;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign sel_a = bus.req_a[arb_idx*DATA_W +: DATA_W];
    assign sel_b = bus.req_b[arb_idx*DATA_W +: DATA_W];

    always_comb begin
        lat_a = sel_a;
        lat_b = sel_b;
`ifdef MUL_SWAP_EN
        if (sel_b > sel_a) begin
            lat_a = sel_b;
            lat_b = sel_a;
        end
`endif
    end

    // Requests are only looked at in IDLE; gnt stays quiet while reset is held.
    assign accept = (state_q == StIdle) && arb_valid;

    always_comb begin
        state_d = state_q;
        gnt     = '0;
        dp_data = '0;
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        ld_p    = 1'b0;
        clr_p   = 1'b0;
        dec_b   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    gnt     = reset_n ? arb_gnt : '0;
                    state_d = StLoadA;
                end
            end
            StLoadA: begin
                dp_data = a_q;
                ld_a    = 1'b1;
                state_d = StLoadB;
            end
            StLoadB: begin
                dp_data = b_q;
                ld_b    = 1'b1;
                clr_p   = 1'b1;
                state_d = StMul;
            end
            StMul: begin
                if (bus.eqz) begin
                    state_d = StDone;
                end else begin
                    ld_p  = 1'b1;
                    dec_b = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            ptr_q      <= ID_W'(NUM_REQ - 1);
            id_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q   <= lat_a;
                b_q   <= lat_b;
                id_q  <= arb_idx;
                ptr_q <= arb_idx;
            end
            // Capture Y on the cycle B reaches zero; it is stable from here on.
            if (state_q == StMul && bus.eqz) begin
                rsp_data_q <= bus.dp_y;
                rsp_id_q   <= id_q;
            end
        end
    end

    assign bus.gnt       = gnt;
    assign bus.busy      = (state_q != StIdle);
    assign bus.rsp_valid = (state_q == StDone);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.dp_data   = dp_data;
    assign bus.LdA       = ld_a;
    assign bus.LdB       = ld_b;
    assign bus.LdP       = ld_p;
    assign bus.clrP      = clr_p;
    assign bus.decB      = dec_b;

endmodule

// File: doc/mul_rr_sched.md
Name: mul_rr_sched

Overview:
- Round-robin scheduler that shares one repeated-addition multiplier datapath between NUM_REQ requesters.
- It accepts a request and latches that requester's operands. It then sequences the datapath controls (LdA, LdB, clrP, LdP, decB) until eqz.
- It returns the product with the requester ID.
- It replaces the single-user start/done control path when several masters share the multiplier.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 16, operand/product width; must match the datapath.
- ID_W, $clog2(NUM_REQ), requester index width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request level.
- req_a  in  NUM_REQ*DATA_W  operand A, requester i at bits [i*DATA_W +: DATA_W].
- req_b  in  NUM_REQ*DATA_W  operand B, same packing.
- gnt  out  NUM_REQ  one-hot acceptance pulse, 1 cycle.
- busy  out  1  high from the cycle after acceptance through the DONE cycle.
- rsp_valid  out  1  result pulse, 1 cycle, no backpressure.
- rsp_id  out  ID_W  requester owning rsp_data.
- rsp_data  out  DATA_W  product, modulo 2^DATA_W.
- dp_data  out  DATA_W  drives datapath data_in.
- LdA, LdB, LdP, clrP, decB  out  1 each  datapath controls.
- eqz  in  1  datapath B==0 flag, combinational from the B register.
- dp_y  in  DATA_W  datapath P register (Y).

Behaviour:
- Reset (async, while reset_n=0): FSM=IDLE; RR pointer=NUM_REQ-1, so req[0] wins first. gnt, busy, rsp_valid, LdA, LdB, LdP, clrP, decB, dp_data, rsp_id and rsp_data are all 0. A reset mid-operation aborts it with no response. The datapath is not reset; the next job's clrP, LdA and LdB overwrite its state.
- FSM states: IDLE, LOAD_A, LOAD_B, MUL, DONE.
- IDLE: if any req bit is set, grant the first set bit searching from pointer+1, wrapping at NUM_REQ.
  - Same cycle: gnt[k]=1; latch req_a[k], req_b[k] and k into internal registers; pointer<=k; next state LOAD_A.
  - Requests are sampled only in IDLE. Requests arriving while busy wait.
  - A requester holds req plus operands until it sees gnt, and may drop or change them afterwards.
  - A req deasserted before grant is never served.
- LOAD_A: dp_data=A_lat, LdA=1.
- LOAD_B: dp_data=B_lat, LdB=1, clrP=1.
- MUL:
  - If eqz=0: LdP=1 and decB=1 (P+=A, B-=1); stay in MUL.
  - If eqz=1: all controls 0; rsp_data<=dp_y, rsp_id<=latched id; go to DONE.
- DONE: rsp_valid=1 for one cycle, then IDLE. A new grant is possible in the IDLE cycle that follows.
- Latency: grant at cycle t gives rsp_valid at t+4+B_eff. B_eff is the operand loaded into datapath B; B=0 gives latency 4 and result 0.
- Throughput: one job per B_eff+5 cycles.
- Controls are registered (Moore): asserted exactly during their state cycle, never two loads in one cycle. dp_data is 0 outside LOAD_A/LOAD_B.
- Overflow: the product truncates to DATA_W bits, matching the datapath; no flag.
- Fairness: after k is served, k has lowest priority. Any continuously requesting master is served within NUM_REQ-1 other jobs.

Optional Feature:
- MUL_SWAP_EN defined:
  - In IDLE the latch stage compares operands; if req_b > req_a they are swapped, so B_eff=min(A,B).
  - This reduces iterations; the product is unchanged (commutative, same modulo).
- MUL_SWAP_EN undefined: B_eff=req_b exactly, no comparator.

Decomposition:
- Package mul_sched_pkg: FSM state enum (IDLE, LOAD_A, LOAD_B, MUL, DONE), localparam defaults for NUM_REQ and DATA_W.
- Sub-module rr_arbiter (NUM_REQ): inputs req, pointer; output one-hot grant plus encoded index; purely combinational. The pointer register stays in the parent.
- Everything else lives in mul_rr_sched.

Test Plan:
- Reset then req[0], A=7, B=5 -> gnt=0001 in one cycle; LdA, LdB+clrP, then 5 LdP/decB cycles; rsp_valid 9 cycles after gnt with rsp_id=0, rsp_data=35.
- req=1111, each requester i gets A=i+2, B=3 -> grant order 0,1,2,3 and responses 6, 9, 12, 15 with matching ids; then req[1] alone re-wins.
- B=0, A=1234 -> no LdP/decB cycles; rsp_data=0, latency 4.
- A=300, B=300 -> rsp_data = 90000 mod 65536 = 24464.
- reset_n low during MUL of a 3*10 job -> all outputs 0 immediately, no rsp_valid; a following 3*10 job returns 30.
- MUL_SWAP_EN, A=2, B=200 -> rsp_data=400 at latency 6. Undefined: latency 204.
